// File: rtl/usr_step_controller.sv
// Step sequencer for a 4-bit universal shift register.
// A prescaler produces one step strobe every TICK_DIV cycles. Each accepted start
// runs one fixed program: a parallel load, SHIFT_COUNT right shifts, then
// SHIFT_COUNT left shifts. The register may act only when o_step_en is high.
module usr_step_controller #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned SHIFT_COUNT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_hold,
  input  logic [3:0] i_load_data,
  input  logic       i_ser_in,
  output logic [1:0] o_sel,
  output logic       o_step_en,
  output logic [3:0] o_par_data,
  output logic       o_ser,
  output logic       o_busy,
  output logic       o_done
);

  // Mode commands understood by the shift register.
  localparam logic [1:0] SelHold  = 2'b00;
  localparam logic [1:0] SelShr   = 2'b01;
  localparam logic [1:0] SelShl   = 2'b10;
  localparam logic [1:0] SelLoad  = 2'b11;

  localparam logic [CNT_W-1:0] CntMax   = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]       StepLast = 4'(SHIFT_COUNT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShr,
    StShl,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       step_cnt_q, step_cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             step_en_q, step_en_d;
  logic [3:0]       par_data_q, par_data_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;

  logic             running;
  logic             tick;

  // Prescaler runs only while a program is stepping; hold freezes it in place.
  assign running = (state_q == StLoad) || (state_q == StShr) || (state_q == StShl);
  assign tick    = running && (cnt_q == CntMax) && !i_hold;

  // Next-state, prescaler and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_cnt_d = step_cnt_q;
    sel_d      = SelHold;
    step_en_d  = 1'b0;
    par_data_d = par_data_q;
    ser_d      = ser_q;
    done_d     = 1'b0;

    if (!running) begin
      cnt_d = '0;
    end else if (!i_hold) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        step_cnt_d = '0;
        if (i_start) begin
          par_data_d = i_load_data;
          ser_d      = i_ser_in;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (tick) begin
          step_en_d = 1'b1;
          sel_d     = SelLoad;
          state_d   = StShr;
        end
      end
      StShr: begin
        if (tick) begin
          step_en_d = 1'b1;
          sel_d     = SelShr;
          if (step_cnt_q == StepLast) begin
            step_cnt_d = '0;
            state_d    = StShl;
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
      end
      StShl: begin
        if (tick) begin
          step_en_d = 1'b1;
          sel_d     = SelShl;
          if (step_cnt_q == StepLast) begin
            step_cnt_d = '0;
            state_d    = StDone;
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; synchronous reset wins over every other input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      step_cnt_q <= '0;
      sel_q      <= SelHold;
      step_en_q  <= 1'b0;
      par_data_q <= '0;
      ser_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_cnt_q <= step_cnt_d;
      sel_q      <= sel_d;
      step_en_q  <= step_en_d;
      par_data_q <= par_data_d;
      ser_q      <= ser_d;
      done_q     <= done_d;
    end
  end

  assign o_sel      = sel_q;
  assign o_step_en  = step_en_q;
  assign o_par_data = par_data_q;
  assign o_ser      = ser_q;
  assign o_busy     = (state_q != StIdle);
  assign o_done     = done_q;

endmodule

// File: tb/tb_usr_step_controller.sv
// Bench for usr_step_controller with TICK_DIV=4, SHIFT_COUNT=2.
module tb_usr_step_controller;

  localparam int TD = 4;
  localparam int N  = 2;

  logic       clk;
  logic       i_rst, i_start, i_hold, i_ser_in;
  logic [3:0] i_load_data;
  logic [1:0] o_sel;
  logic       o_step_en, o_ser, o_busy, o_done;
  logic [3:0] o_par_data;

  usr_step_controller #(
    .TICK_DIV   (TD),
    .CNT_W      (3),
    .SHIFT_COUNT(N)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_hold     (i_hold),
    .i_load_data(i_load_data),
    .i_ser_in   (i_ser_in),
    .o_sel      (o_sel),
    .o_step_en  (o_step_en),
    .o_par_data (o_par_data),
    .o_ser      (o_ser),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {sel, step_en, par_data, ser, busy, done}
  logic [9:0] dut_vec;
  assign dut_vec = {o_sel, o_step_en, o_par_data, o_ser, o_busy, o_done};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counts un-held edges since the accepted start and
  // fires strobe k when that count reaches k*TD.
  int         m_phase   = 0;  // 0 idle, 1 stepping, 2 finishing
  int         m_elapsed = 0;
  int         m_strobes = 0;
  logic [1:0] m_sel = '0;
  logic       m_en = 1'b0, m_ser = 1'b0, m_done = 1'b0;
  logic [3:0] m_par = '0;
  logic [9:0] m_out = '0;

  function automatic logic [1:0] sel_for(input int k);
    if (k == 1) return 2'b11;
    else if (k <= 1 + N) return 2'b01;
    else return 2'b10;
  endfunction

  task automatic model(input logic rst, input logic start, input logic hold,
                       input logic [3:0] ld, input logic ser);
    if (rst) begin
      m_phase = 0; m_elapsed = 0; m_strobes = 0;
      m_sel = '0; m_en = 1'b0; m_par = '0; m_ser = 1'b0; m_done = 1'b0;
    end else begin
      m_sel = '0; m_en = 1'b0; m_done = 1'b0;
      case (m_phase)
        0: if (start) begin
          m_par = ld; m_ser = ser; m_phase = 1; m_elapsed = 0; m_strobes = 0;
        end
        1: if (!hold) begin
          m_elapsed++;
          if (m_elapsed == (m_strobes + 1) * TD) begin
            m_strobes++;
            m_en  = 1'b1;
            m_sel = sel_for(m_strobes);
            if (m_strobes == 1 + 2 * N) m_phase = 2;
          end
        end
        default: begin
          m_done  = 1'b1;
          m_phase = 0;
        end
      endcase
    end
    m_out = {m_sel, m_en, m_par, m_ser, (m_phase != 0), m_done};
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {sel,en,par,ser,busy,done}=%b required %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // One clock: drive on the falling edge, advance the model on the rising edge,
  // compare shortly after.
  task automatic step(input logic rst, input logic start, input logic hold,
                      input logic [3:0] ld, input logic ser);
    @(negedge clk);
    i_rst = rst; i_start = start; i_hold = hold; i_load_data = ld; i_ser_in = ser;
    @(posedge clk);
    model(rst, start, hold, ld, ser);
    #1;
    check("model", dut_vec, m_out);
  endtask

  typedef struct {
    logic       start;
    logic [3:0] ld;
    logic       ser;
    logic [1:0] sel;
    logic       en;
    logic [3:0] par;
    logic       sr;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[24];
  int   edges[$];
  int   sels[$];
  int   dones[$];

  task automatic record(input int i);
    if (o_step_en) begin
      edges.push_back(i);
      sels.push_back(int'(o_sel));
    end
    if (o_done) dones.push_back(i);
  endtask

  task automatic clear_rec();
    edges.delete(); sels.delete(); dones.delete();
  endtask

  initial begin
    int se[5];
    int ss[5];

    i_rst = 1'b0; i_start = 1'b0; i_hold = 1'b0; i_load_data = '0; i_ser_in = 1'b0;

    // Scenario 1 table: row i = inputs at edge i (edge 0 accepts start) and outputs after it.
    se = '{4, 8, 12, 16, 20};
    ss = '{3, 1, 1, 2, 2};
    for (int i = 0; i < 24; i++) begin
      tbl[i].start = (i == 0);
      tbl[i].ld    = 4'b1011;
      tbl[i].ser   = 1'b1;
      tbl[i].sel   = 2'b00;
      tbl[i].en    = 1'b0;
      tbl[i].par   = 4'b1011;
      tbl[i].sr    = 1'b1;
      tbl[i].busy  = (i <= 20);
      tbl[i].done  = (i == 21);
    end
    for (int j = 0; j < 5; j++) begin
      tbl[se[j]].en  = 1'b1;
      tbl[se[j]].sel = 2'(ss[j]);
    end

    // Reset state
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    check("reset_outputs", dut_vec, 10'b0);

    // 1. Basic program
    for (int i = 0; i < 24; i++) begin
      step(1'b0, tbl[i].start, 1'b0, tbl[i].ld, tbl[i].ser);
      check($sformatf("tbl[%0d]", i), dut_vec,
            {tbl[i].sel, tbl[i].en, tbl[i].par, tbl[i].sr, tbl[i].busy, tbl[i].done});
    end

    // 2. Hold for three cycles starting at edge 6
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    clear_rec();
    for (int i = 0; i < 27; i++) begin
      step(1'b0, (i == 0), (i >= 6 && i <= 8), 4'b1011, 1'b1);
      record(i);
    end
    check_int("hold_strobe_count", edges.size(), 5);
    if (edges.size() == 5) begin
      se = '{4, 11, 15, 19, 23};
      for (int j = 0; j < 5; j++) begin
        check_int($sformatf("hold_strobe_edge%0d", j), edges[j], se[j]);
        check_int($sformatf("hold_strobe_sel%0d", j), sels[j], ss[j]);
      end
    end

    // 3. Start while busy is ignored
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    clear_rec();
    for (int i = 0; i < 24; i++) begin
      step(1'b0, (i == 0 || i == 10), 1'b0, (i == 10) ? 4'b0001 : 4'b1011, 1'b1);
      record(i);
    end
    check_int("busy_start_par", int'(o_par_data), 4'b1011);
    check_int("busy_start_strobes", edges.size(), 5);
    check_int("busy_start_dones", dones.size(), 1);

    // 4. Reset mid-program at edge 9 (in the shift-right phase)
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    clear_rec();
    for (int i = 0; i < 9; i++) begin
      step(1'b0, (i == 0), 1'b0, 4'b1011, 1'b1);
      record(i);
    end
    check_int("midreset_strobes_before", edges.size(), 2);
    step(1'b1, 1'b0, 1'b0, 4'b1011, 1'b1);
    check("midreset_outputs", dut_vec, 10'b0);
    clear_rec();
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'b1011, 1'b1);
      record(i);
    end
    check_int("midreset_strobes_after", edges.size(), 0);
    check_int("midreset_dones_after", dones.size(), 0);

    // 5. Back-to-back starts with start held high
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    clear_rec();
    for (int i = 0; i < 46; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'b1011, 1'b1);
      record(i);
    end
    check_int("b2b_strobes", edges.size(), 10);
    if (edges.size() >= 10) begin
      check_int("b2b_second_first", edges[5], 26);
      check_int("b2b_tenth", edges[9], 42);
    end
    check_int("b2b_dones", dones.size(), 2);
    if (dones.size() >= 2) begin
      check_int("b2b_done0", dones[0], 21);
      check_int("b2b_done1", dones[1], 43);
    end

    // 6. Reset and start together in idle
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b1011, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
    check_int("rst_start_busy", int'(o_busy), 0);
    check_int("rst_start_par", int'(o_par_data), 0);
    step(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
    check_int("rst_start_busy_after", int'(o_busy), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
